// File: rtl/gf16_exp.sv
`default_nettype none
// ============================================================================
//  Module   : gf16_exp
//  Purpose  : Sequential exponentiation z = a^e in GF(2^4), P(x)=x^4+x^3+1,
//             MSB-first square-and-multiply over one time-shared multiplier.
//  Options  : GF16_INV_EN - adds input 'inv'; when sampled high with 'start'
//             the exponent is forced to 14 so that z = a^-1 (EW >= 4 needed).
//  Revision : 1.0 - initial release
// ============================================================================
module gf16_exp #(
    parameter int EW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef GF16_INV_EN
    input  logic          inv,
`endif
    input  logic          start,
    input  logic [3:0]    a,
    input  logic [EW-1:0] e,
    output logic          busy,
    output logic          done,
    output logic [3:0]    z
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      acc_q, acc_d;
    logic [3:0]      a_q, a_d;
    logic [EW-1:0]   e_q, e_d;
    logic [IW-1:0]   i_q, i_d;
    logic [3:0]      z_q, z_d;

    logic [3:0]      w_op_b;
    logic [6:0]      w_raw;
    logic [3:0]      w_prod;
    logic [EW-1:0]   w_e_eff;

`ifdef GF16_INV_EN
    localparam logic [EW-1:0] c_INV_EXP = EW'(14);
`endif

    // Single shared multiplier: acc*acc while squaring, acc*a_reg in MUL.
    always_comb begin
        w_op_b = (state_q == MUL) ? a_q : acc_q;
        w_raw  = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_op_b[k]) w_raw = w_raw ^ (7'(acc_q) << k);
        end
        // Fold high terms down from the top using x^4 = x^3 + 1.
        for (int k = 6; k >= 4; k--) begin
            if (w_raw[k]) w_raw = w_raw ^ (7'(5'b11001) << (k - 4));
        end
        w_prod = w_raw[3:0];
    end

    // Next-state, datapath updates and the exponent source selection.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        e_d     = e_q;
        i_d     = i_q;
        z_d     = z_q;
`ifdef GF16_INV_EN
        w_e_eff = inv ? c_INV_EXP : e;
`else
        w_e_eff = e;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    e_d     = w_e_eff;
                    acc_d   = 4'b0001;
                    i_d     = IW'(EW - 1);
                    state_d = SQR;
                end
            end
            SQR: begin
                acc_d = w_prod;
                if (e_q[i_q]) begin
                    state_d = MUL;
                end else if (i_q == '0) begin
                    // z is loaded on the same edge that enters DONE so it is
                    // valid throughout the done pulse.
                    z_d     = w_prod;
                    state_d = DONE;
                end else begin
                    i_d = i_q - IW'(1);
                end
            end
            MUL: begin
                acc_d = w_prod;
                if (i_q == '0) begin
                    z_d     = w_prod;
                    state_d = DONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = SQR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 4'b0001;
            a_q     <= '0;
            e_q     <= '0;
            i_q     <= IW'(EW - 1);
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            e_q     <= e_d;
            i_q     <= i_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign z    = z_q;

endmodule
`default_nettype wire
